imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter.sv | 121 ++++++++++++
 tb/tb_imem_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// Shared instruction-memory arbiter: CPU fetch port in RUN, loader write port in LOAD, one FLUSH cycle back.
// Optional macro IMEM_ARB_BOUNDS_CHK_EN drops loader writes whose address lies above the memory range.
module imem_arbiter #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [31:0]       f_addr,
  output logic [31:0]       f_rdata,
  output logic              f_valid,
  output logic              stall,
  input  logic              ld_start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [31:0]       ld_addr,
  input  logic [31:0]       ld_data,
  input  logic              ld_done,
  output logic              ld_err,
  output logic [CNT_W-1:0]  ld_count,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {RUN, LOAD, FLUSH} state_e;

  state_e             state_q, state_d;
  logic               f_valid_q, f_valid_d;
  logic               ld_err_q, ld_err_d;
  logic [CNT_W-1:0]   ld_count_q, ld_count_d;
  logic               ld_legal;
  logic               unused_bits;

`ifdef IMEM_ARB_BOUNDS_CHK_EN
  assign ld_legal = (ld_addr[1:0] == 2'b00) && (ld_addr[31:ADDR_W+2] == '0);
`else
  assign ld_legal = (ld_addr[1:0] == 2'b00);
`endif

  // Byte-offset bits of the fetch address and loader upper bits may go unused.
  assign unused_bits = ^{f_addr[31:ADDR_W+2], f_addr[1:0], ld_addr[31:ADDR_W+2]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      f_valid_q  <= 1'b0;
      ld_err_q   <= 1'b0;
      ld_count_q <= '0;
    end else begin
      state_q    <= state_d;
      f_valid_q  <= f_valid_d;
      ld_err_q   <= ld_err_d;
      ld_count_q <= ld_count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    f_valid_d  = 1'b0;
    ld_err_d   = ld_err_q;
    ld_count_d = ld_count_q;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    stall      = 1'b0;
    ld_ready   = 1'b0;
    case (state_q)
      RUN: begin
        mem_en    = f_req;
        mem_addr  = f_addr[ADDR_W+1:2];
        f_valid_d = f_req;
        if (ld_start) begin
          state_d    = LOAD;
          ld_err_d   = 1'b0;
          ld_count_d = '0;
        end
      end
      LOAD: begin
        stall    = 1'b1;
        ld_ready = 1'b1;
        if (ld_valid) begin
          if (ld_legal) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = ld_addr[ADDR_W+1:2];
            mem_wdata = ld_data;
            if (ld_count_q != '1) ld_count_d = ld_count_q + CNT_W'(1);
          end else begin
            ld_err_d = 1'b1;
          end
        end
        if (ld_done) state_d = FLUSH;
      end
      FLUSH: begin
        stall   = 1'b1;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    // Memory-side and handshake outputs are forced idle while reset is held.
    if (rst) begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      stall     = 1'b0;
      ld_ready  = 1'b0;
    end
  end

  assign f_valid  = f_valid_q;
  assign f_rdata  = f_valid_q ? mem_rdata : '0;
  assign ld_err   = ld_err_q;
  assign ld_count = ld_count_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed self-checking bench for imem_arbiter with a behavioural 1-cycle-latency memory.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_req = 1'b0;
  logic [31:0] f_addr = '0;
  logic [31:0] f_rdata;
  logic        f_valid;
  logic        stall;
  logic        ld_start = 1'b0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [31:0] ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic        ld_done = 1'b0;
  logic        ld_err;
  logic [15:0] ld_count;
  logic        mem_en;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  logic [31:0] mem [0:1023];
  int nvec = 0;
  int nerr = 0;

  imem_arbiter #(.ADDR_W(10), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata),
    .f_valid(f_valid), .stall(stall), .ld_start(ld_start), .ld_valid(ld_valid),
    .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data), .ld_done(ld_done),
    .ld_err(ld_err), .ld_count(ld_count), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    f_req = 1'b1; f_addr = 32'h4; ld_valid = 1'b1; ld_addr = 32'h8;
    #1;
    nvec++; if (f_valid !== 1'b0) begin nerr++; $display("FAIL rst_f_valid got %0h exp 0", f_valid); end
    nvec++; if (f_rdata !== 32'h0) begin nerr++; $display("FAIL rst_f_rdata got %h exp 0", f_rdata); end
    nvec++; if (stall !== 1'b0) begin nerr++; $display("FAIL rst_stall got %0h exp 0", stall); end
    nvec++; if (ld_ready !== 1'b0) begin nerr++; $display("FAIL rst_ld_ready got %0h exp 0", ld_ready); end
    nvec++; if (ld_err !== 1'b0) begin nerr++; $display("FAIL rst_ld_err got %0h exp 0", ld_err); end
    nvec++; if (ld_count !== 16'h0) begin nerr++; $display("FAIL rst_ld_count got %h exp 0", ld_count); end
    nvec++; if (mem_en !== 1'b0) begin nerr++; $display("FAIL rst_mem_en got %0h exp 0", mem_en); end
    nvec++; if (mem_we !== 1'b0) begin nerr++; $display("FAIL rst_mem_we got %0h exp 0", mem_we); end
    nvec++; if (mem_addr !== 10'h0) begin nerr++; $display("FAIL rst_mem_addr got %h exp 0", mem_addr); end
    nvec++; if (mem_wdata !== 32'h0) begin nerr++; $display("FAIL rst_mem_wdata got %h exp 0", mem_wdata); end
  endtask

  task automatic test_fetch();
    step();
    rst = 1'b0; f_req = 1'b1; f_addr = 32'h0; ld_valid = 1'b1; ld_done = 1'b1; ld_addr = 32'h40;
    #1;
    nvec++; if (mem_en !== 1'b1) begin nerr++; $display("FAIL fetch0_mem_en got %0h exp 1", mem_en); end
    nvec++; if (mem_we !== 1'b0) begin nerr++; $display("FAIL run_ld_ignored_we got %0h exp 0", mem_we); end
    nvec++; if (ld_ready !== 1'b0) begin nerr++; $display("FAIL run_ld_ready got %0h exp 0", ld_ready); end
    nvec++; if (mem_addr !== 10'h0) begin nerr++; $display("FAIL fetch0_mem_addr got %h exp 0", mem_addr); end
    step();
    ld_valid = 1'b0; ld_done = 1'b0; f_addr = 32'h4;
    #1;
    nvec++; if (f_valid !== 1'b1) begin nerr++; $display("FAIL fetch0_valid got %0h exp 1", f_valid); end
    nvec++; if (f_rdata !== 32'h1000_0000) begin nerr++; $display("FAIL fetch0_rdata got %h exp 10000000", f_rdata); end
    nvec++; if (mem_addr !== 10'h1) begin nerr++; $display("FAIL fetch1_mem_addr got %h exp 1", mem_addr); end
    step();
    f_addr = 32'h8;
    #1;
    nvec++; if (f_rdata !== 32'h1000_0001) begin nerr++; $display("FAIL fetch1_rdata got %h exp 10000001", f_rdata); end
    step();
    f_req = 1'b0;
    #1;
    nvec++; if (f_rdata !== 32'h1000_0002) begin nerr++; $display("FAIL fetch2_rdata got %h exp 10000002", f_rdata); end
    nvec++; if (stall !== 1'b0) begin nerr++; $display("FAIL fetch_stall got %0h exp 0", stall); end
    step();
    #1;
    nvec++; if (f_valid !== 1'b0) begin nerr++; $display("FAIL fetch_idle_valid got %0h exp 0", f_valid); end
  endtask

  task automatic test_load();
    f_req = 1'b1; f_addr = 32'hC; ld_start = 1'b1;
    #1;
    nvec++; if (mem_addr !== 10'h3) begin nerr++; $display("FAIL enter_fetch_addr got %h exp 3", mem_addr); end
    step();
    ld_start = 1'b0; f_addr = 32'h0; ld_valid = 1'b1; ld_addr = 32'h0; ld_data = 32'h0000_0013;
    #1;
    nvec++; if (f_valid !== 1'b1) begin nerr++; $display("FAIL enter_fetch_valid got %0h exp 1", f_valid); end
    nvec++; if (f_rdata !== 32'h1000_0003) begin nerr++; $display("FAIL enter_fetch_rdata got %h exp 10000003", f_rdata); end
    nvec++; if (stall !== 1'b1) begin nerr++; $display("FAIL load_stall got %0h exp 1", stall); end
    nvec++; if (ld_ready !== 1'b1) begin nerr++; $display("FAIL load_ready got %0h exp 1", ld_ready); end
    nvec++; if ({mem_en, mem_we} !== 2'b11) begin nerr++; $display("FAIL load_en_we got %b exp 11", {mem_en, mem_we}); end
    nvec++; if (mem_addr !== 10'h0) begin nerr++; $display("FAIL load_w0_addr got %h exp 0", mem_addr); end
    nvec++; if (mem_wdata !== 32'h0000_0013) begin nerr++; $display("FAIL load_w0_data got %h exp 00000013", mem_wdata); end
    nvec++; if (ld_count !== 16'h0) begin nerr++; $display("FAIL load_count0 got %h exp 0", ld_count); end
    step();
    ld_start = 1'b1; ld_addr = 32'h4; ld_data = 32'h0050_0093;
    #1;
    nvec++; if (f_valid !== 1'b0) begin nerr++; $display("FAIL load_f_valid got %0h exp 0", f_valid); end
    nvec++; if (ld_count !== 16'h1) begin nerr++; $display("FAIL load_count1 got %h exp 1", ld_count); end
    nvec++; if (mem_addr !== 10'h1) begin nerr++; $display("FAIL load_w1_addr got %h exp 1", mem_addr); end
    step();
    ld_start = 1'b0; ld_valid = 1'b0; ld_done = 1'b1;
    #1;
    nvec++; if (ld_count !== 16'h2) begin nerr++; $display("FAIL load_count2 got %h exp 2", ld_count); end
    nvec++; if (mem_en !== 1'b0) begin nerr++; $display("FAIL load_idle_en got %0h exp 0", mem_en); end
    step();
    ld_done = 1'b0; f_req = 1'b1; f_addr = 32'h0;
    #1;
    nvec++; if (stall !== 1'b1) begin nerr++; $display("FAIL flush_stall got %0h exp 1", stall); end
    nvec++; if (ld_ready !== 1'b0) begin nerr++; $display("FAIL flush_ready got %0h exp 0", ld_ready); end
    nvec++; if (mem_en !== 1'b0) begin nerr++; $display("FAIL flush_mem_en got %0h exp 0", mem_en); end
    step();
    #1;
    nvec++; if (stall !== 1'b0) begin nerr++; $display("FAIL post_flush_stall got %0h exp 0", stall); end
    nvec++; if (mem_en !== 1'b1) begin nerr++; $display("FAIL post_flush_en got %0h exp 1", mem_en); end
    step();
    f_addr = 32'h4;
    #1;
    nvec++; if (f_rdata !== 32'h0000_0013) begin nerr++; $display("FAIL new_img0 got %h exp 00000013", f_rdata); end
    step();
    f_req = 1'b0;
    #1;
    nvec++; if (f_rdata !== 32'h0050_0093) begin nerr++; $display("FAIL new_img1 got %h exp 00500093", f_rdata); end
    step();
  endtask

  task automatic test_misaligned();
    ld_start = 1'b1;
    #1;
    step();
    ld_start = 1'b0; ld_valid = 1'b1; ld_addr = 32'h6; ld_data = 32'h0000_0BAD;
    #1;
    nvec++; if ({mem_en, mem_we} !== 2'b00) begin nerr++; $display("FAIL misal_en_we got %b exp 00", {mem_en, mem_we}); end
    nvec++; if (ld_ready !== 1'b1) begin nerr++; $display("FAIL misal_ready got %0h exp 1", ld_ready); end
    step();
    ld_valid = 1'b0; ld_done = 1'b1;
    #1;
    nvec++; if (ld_err !== 1'b1) begin nerr++; $display("FAIL misal_err got %0h exp 1", ld_err); end
    nvec++; if (ld_count !== 16'h0) begin nerr++; $display("FAIL misal_count got %h exp 0", ld_count); end
    step();
    ld_done = 1'b0;
    #1;
    step();
    f_req = 1'b1; f_addr = 32'h4;
    #1;
    nvec++; if (ld_err !== 1'b1) begin nerr++; $display("FAIL misal_err_run got %0h exp 1", ld_err); end
    step();
    f_req = 1'b0; ld_start = 1'b1;
    #1;
    nvec++; if (f_rdata !== 32'h0050_0093) begin nerr++; $display("FAIL misal_mem_kept got %h exp 00500093", f_rdata); end
    step();
    ld_start = 1'b0;
    #1;
    nvec++; if (ld_err !== 1'b0) begin nerr++; $display("FAIL err_clear_on_load got %0h exp 0", ld_err); end
  endtask

  task automatic test_bounds();
    logic        exp_en;
    logic        exp_err;
    logic [15:0] exp_cnt;
`ifdef IMEM_ARB_BOUNDS_CHK_EN
    exp_en = 1'b0; exp_err = 1'b1; exp_cnt = 16'h0;
`else
    exp_en = 1'b1; exp_err = 1'b0; exp_cnt = 16'h1;
`endif
    ld_valid = 1'b1; ld_addr = 32'h1000; ld_data = 32'hCAFE_0001;
    #1;
    nvec++; if (mem_en !== exp_en) begin nerr++; $display("FAIL bounds_en got %0h exp %0h", mem_en, exp_en); end
    step();
    ld_valid = 1'b0;
    #1;
    nvec++; if (ld_err !== exp_err) begin nerr++; $display("FAIL bounds_err got %0h exp %0h", ld_err, exp_err); end
    nvec++; if (ld_count !== exp_cnt) begin nerr++; $display("FAIL bounds_count got %h exp %h", ld_count, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w0;
    logic [15:0] exp_cnt;
`ifdef IMEM_ARB_BOUNDS_CHK_EN
    exp_w0 = 32'h0000_0013; exp_cnt = 16'h1;
`else
    exp_w0 = 32'hCAFE_0001; exp_cnt = 16'h2;
`endif
    ld_valid = 1'b1; ld_done = 1'b1; ld_addr = 32'h8; ld_data = 32'hDEAD_BEEF;
    #1;
    nvec++; if ({mem_we, mem_addr} !== {1'b1, 10'h2}) begin nerr++; $display("FAIL done_wr got we=%0h addr=%h exp we=1 addr=2", mem_we, mem_addr); end
    step();
    ld_valid = 1'b0; ld_done = 1'b0;
    #1;
    nvec++; if ({stall, ld_ready} !== 2'b10) begin nerr++; $display("FAIL done_flush got %b exp 10", {stall, ld_ready}); end
    nvec++; if (ld_count !== exp_cnt) begin nerr++; $display("FAIL done_count got %h exp %h", ld_count, exp_cnt); end
    step();
    f_req = 1'b1; f_addr = 32'h0;
    #1;
    step();
    f_addr = 32'h8;
    #1;
    nvec++; if (f_rdata !== exp_w0) begin nerr++; $display("FAIL bounds_word0 got %h exp %h", f_rdata, exp_w0); end
    step();
    f_req = 1'b0;
    #1;
    nvec++; if (f_rdata !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL done_word2 got %h exp deadbeef", f_rdata); end
    step();
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] exp_rd [0:3];
    exp_rd[0] = 32'hA000_0000; exp_rd[1] = 32'hA000_0001;
    exp_rd[2] = 32'hA000_0002; exp_rd[3] = 32'h1000_0007;
    ld_start = 1'b1;
    #1;
    step();
    ld_start = 1'b0; ld_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ld_addr = 32'h10 + 32'(4 * i); ld_data = 32'hA000_0000 + 32'(i);
      #1;
      step();
    end
    ld_addr = 32'h1C; ld_data = 32'h0000_00FF;
    #1;
    nvec++; if (ld_count !== 16'h3) begin nerr++; $display("FAIL midload_count got %h exp 3", ld_count); end
    #1;
    rst = 1'b1;
    #1;
    nvec++; if ({stall, ld_ready, ld_err, f_valid} !== 4'b0000) begin nerr++; $display("FAIL async_rst_flags got %b exp 0000", {stall, ld_ready, ld_err, f_valid}); end
    nvec++; if (ld_count !== 16'h0) begin nerr++; $display("FAIL async_rst_count got %h exp 0", ld_count); end
    nvec++; if ({mem_en, mem_we, mem_addr, mem_wdata, f_rdata} !== '0) begin nerr++; $display("FAIL async_rst_mem got en=%0h we=%0h addr=%h wd=%h rd=%h exp 0", mem_en, mem_we, mem_addr, mem_wdata, f_rdata); end
    step();
    step();
    rst = 1'b0; ld_valid = 1'b0; f_req = 1'b1; f_addr = 32'h10;
    #1;
    nvec++; if (stall !== 1'b0) begin nerr++; $display("FAIL post_rst_stall got %0h exp 0", stall); end
    for (int i = 0; i < 4; i++) begin
      step();
      f_addr = 32'h14 + 32'(4 * i);
      if (i == 3) f_req = 1'b0;
      #1;
      nvec++; if (f_rdata !== exp_rd[i]) begin nerr++; $display("FAIL post_rst_word%0d got %h exp %h", i, f_rdata, exp_rd[i]); end
    end
    step();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + 32'(i);
    test_reset();
    test_fetch();
    test_load();
    test_misaligned();
    test_bounds();
    test_back_to_back();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
